// File: rtl/imem_pkg.sv
// Shared types and constants for the multi-cycle instruction-memory responder.
package imem_pkg;

    localparam int ADDR_W          = 16;
    localparam int WORD_W          = 16;
    localparam int DEFAULT_LATENCY = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/imem_array.sv
// Program-image storage: synchronous write, asynchronous read, never cleared by reset.
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [WORD_W-1:0]     i_wdata,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [WORD_W-1:0]     o_rdata
);

    logic [WORD_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder with req/stall/done handshake and fixed latency.
// Optional misaligned-address checking is enabled by defining IMEM_ALIGN_CHECK_EN.
module imem_responder
    import imem_pkg::*;
#(
    parameter int LATENCY    = DEFAULT_LATENCY,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [WORD_W-1:0] ld_data,
    output logic              stall,
    output logic              done,
    output logic [WORD_W-1:0] data_out,
    output logic              err
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [WORD_W-1:0] r_word;
    logic              r_wordErr;
    logic              r_stall;
    logic              r_done;
    logic [WORD_W-1:0] r_dataOut;
    logic              r_err;

    logic              w_misalign;
    logic              w_ldWe;
    logic              w_accept;
    logic [WORD_W-1:0] w_rdData;
    logic [WORD_W-1:0] w_fetchWord;
    logic              w_unusedBits;

`ifdef IMEM_ALIGN_CHECK_EN
    assign w_misalign = addr[0];
    assign w_ldWe     = ld_en & ~ld_addr[0];
`else
    assign w_misalign = 1'b0;
    assign w_ldWe     = ld_en;
`endif

    // Upper address bits wrap modulo the depth and are deliberately dropped.
    assign w_unusedBits = ^{addr[ADDR_W-1:DEPTH_LOG2+1], addr[0],
                            ld_addr[ADDR_W-1:DEPTH_LOG2+1], ld_addr[0]};

    imem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .i_clk   (clk),
        .i_we    (w_ldWe),
        .i_waddr (ld_addr[DEPTH_LOG2:1]),
        .i_wdata (ld_data),
        .i_raddr (addr[DEPTH_LOG2:1]),
        .o_rdata (w_rdData)
    );

    assign w_accept    = req && ((r_state == IDLE) || (r_state == RESP));
    assign w_fetchWord = w_misalign ? '0 : w_rdData;

    // Read happens at the accept edge, so a same-edge load is seen only afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_word    <= '0;
            r_wordErr <= 1'b0;
            r_stall   <= 1'b0;
            r_done    <= 1'b0;
            r_dataOut <= '0;
            r_err     <= 1'b0;
        end else begin
            r_stall <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE, RESP: begin
                    if (w_accept) begin
                        r_word    <= w_fetchWord;
                        r_wordErr <= w_misalign;
                        if (LATENCY == 1) begin
                            r_state   <= RESP;
                            r_done    <= 1'b1;
                            r_dataOut <= w_fetchWord;
                            r_err     <= w_misalign;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_INIT;
                            r_stall <= 1'b1;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WAIT: begin
                    if (r_cnt <= 4'd1) begin
                        r_state   <= RESP;
                        r_cnt     <= '0;
                        r_done    <= 1'b1;
                        r_dataOut <= r_word;
                        r_err     <= r_wordErr;
                    end else begin
                        r_cnt   <= r_cnt - 4'd1;
                        r_stall <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign stall    = r_stall;
    assign done     = r_done;
    assign data_out = r_dataOut;
    assign err      = r_err;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one LATENCY=4 instance and one LATENCY=1 instance
// sharing clock, reset and the program-load port.
module tb_imem_responder;

    logic        clk;
    logic        rst;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;

    logic        req4,  req1;
    logic [15:0] addr4, addr1;
    logic        stall4, done4, err4;
    logic        stall1, done1, err1;
    logic [15:0] data4, data1;

    int checkCount = 0;
    int failCount  = 0;

    imem_responder #(.LATENCY(4), .DEPTH_LOG2(10)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .req      (req4),
        .addr     (addr4),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .stall    (stall4),
        .done     (done4),
        .data_out (data4),
        .err      (err4)
    );

    imem_responder #(.LATENCY(1), .DEPTH_LOG2(10)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .req      (req1),
        .addr     (addr1),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .stall    (stall1),
        .done     (done1),
        .data_out (data1),
        .err      (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic loadWord(input logic [15:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        step();
        ld_en   = 1'b0;
    endtask

    // Issues one request on the LATENCY=4 instance and waits (bounded) for done.
    task automatic applyStimulus(input string tag, input logic [15:0] a,
                                 input logic [15:0] expData, input logic expErr);
        int n;
        int stalls;
        req4  = 1'b1;
        addr4 = a;
        step();
        req4  = 1'b0;
        ld_en = 1'b0;
        n      = 1;
        stalls = 0;
        while (!done4 && n < 20) begin
            if (stall4) stalls++;
            step();
            n++;
        end
        checkOutput({tag, " latency"}, 16'(n), 16'd4);
        checkOutput({tag, " stalls"}, 16'(stalls), 16'd3);
        checkOutput({tag, " data"}, data4, expData);
        checkOutput({tag, " err"}, 16'(err4), 16'(expErr));
        step();
        checkOutput({tag, " done drop"}, 16'(done4), 16'd0);
        checkOutput({tag, " err drop"}, 16'(err4), 16'd0);
        checkOutput({tag, " data hold"}, data4, expData);
    endtask

    initial begin
        int doneSeen;
        rst     = 1'b1;
        ld_en   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        req4    = 1'b0;
        addr4   = '0;
        req1    = 1'b0;
        addr1   = '0;
        step();
        step();
        checkOutput("reset stall4", 16'(stall4), 16'd0);
        checkOutput("reset done4", 16'(done4), 16'd0);
        checkOutput("reset data4", data4, 16'h0000);
        checkOutput("reset err4", 16'(err4), 16'd0);
        checkOutput("reset stall1", 16'(stall1), 16'd0);
        checkOutput("reset done1", 16'(done1), 16'd0);
        rst = 1'b0;
        step();

        loadWord(16'h0000, 16'h1111);
        loadWord(16'h0002, 16'h2222);
        loadWord(16'h0004, 16'h1234);
        loadWord(16'h0006, 16'hAAAA);

        applyStimulus("basic 0x0004", 16'h0004, 16'h1234, 1'b0);

        // LATENCY=1: back-to-back accepts, done every cycle, never stalls.
        req1  = 1'b1;
        addr1 = 16'h0000;
        step();
        checkOutput("lat1 done a", 16'(done1), 16'd1);
        checkOutput("lat1 data a", data1, 16'h1111);
        checkOutput("lat1 stall a", 16'(stall1), 16'd0);
        addr1 = 16'h0002;
        step();
        checkOutput("lat1 done b", 16'(done1), 16'd1);
        checkOutput("lat1 data b", data1, 16'h2222);
        checkOutput("lat1 stall b", 16'(stall1), 16'd0);
        addr1 = 16'h0004;
        step();
        req1 = 1'b0;
        checkOutput("lat1 done c", 16'(done1), 16'd1);
        checkOutput("lat1 data c", data1, 16'h1234);
        checkOutput("lat1 stall c", 16'(stall1), 16'd0);
        step();
        checkOutput("lat1 idle done", 16'(done1), 16'd0);
        checkOutput("lat1 idle data", data1, 16'h1234);

        // Same-edge load and accept to word 3: old contents first, new afterwards.
        ld_en   = 1'b1;
        ld_addr = 16'h0006;
        ld_data = 16'hBEEF;
        applyStimulus("rbw old", 16'h0006, 16'hAAAA, 1'b0);
        applyStimulus("rbw new", 16'h0006, 16'hBEEF, 1'b0);

        // Reset in the second WAIT cycle aborts the request.
        req4  = 1'b1;
        addr4 = 16'h0000;
        step();
        req4 = 1'b0;
        step();
        checkOutput("abort wait stall", 16'(stall4), 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("abort stall", 16'(stall4), 16'd0);
        checkOutput("abort done", 16'(done4), 16'd0);
        doneSeen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done4 || stall4) doneSeen++;
        end
        checkOutput("abort no done", 16'(doneSeen), 16'd0);
        applyStimulus("after abort", 16'h0002, 16'h2222, 1'b0);

        applyStimulus("wrap 0x0802", 16'h0802, 16'h2222, 1'b0);
        applyStimulus("wrap 0x0804", 16'h0804, 16'h1234, 1'b0);

`ifdef IMEM_ALIGN_CHECK_EN
        applyStimulus("misaligned", 16'h0003, 16'h0000, 1'b1);
        loadWord(16'h0003, 16'hDEAD);
        applyStimulus("dropped load", 16'h0002, 16'h2222, 1'b0);
`else
        applyStimulus("odd addr", 16'h0003, 16'h2222, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
